// File: rtl/uart_mmio_ctrl_pkg.sv
// Address map and status layout shared by the UART MMIO responder and its FIFOs.
// Offsets are word indices taken from addr[5:2].
package uart_mmio_ctrl_pkg;
    localparam logic [3:0] IO_BASE_NIBBLE = 4'h8;

    localparam logic [3:0] OFF_STATUS = 4'h0;
    localparam logic [3:0] OFF_RX     = 4'h1;
    localparam logic [3:0] OFF_TX     = 4'h2;
    localparam logic [3:0] OFF_CYC    = 4'h4;
    localparam logic [3:0] OFF_INST   = 4'h5;
    localparam logic [3:0] OFF_CLR    = 4'h6;

    localparam int STAT_TX_NOT_FULL  = 0;
    localparam int STAT_RX_NOT_EMPTY = 1;
endpackage

// File: rtl/uart_mmio_ctrl_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; dout is the head entry, combinational.
// Latency: a pushed entry is visible at dout the cycle after the push edge.
// Backpressure: none internally; the caller must gate push on full (or a same-cycle pop) and pop on empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_q[wr_q[AW-1:0]] <= din;
                wr_q                <= wr_q + 1'b1;
            end
            if (pop) begin
                rd_q <= rd_q + 1'b1;
            end
        end
    end

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
    assign dout  = mem_q[rd_q[AW-1:0]];
endmodule

// File: rtl/uart_mmio_ctrl.sv
// CPU MMIO responder for the UART: RX/TX byte FIFOs plus cycle and retired-instruction counters.
// Latency: load data is registered and valid the cycle after re, like the synchronous memories.
// Backpressure: rx_ready drops when RX is full; TX stores while full (and not draining) are dropped.
module uart_mmio_ctrl #(
    parameter int         FIFO_DEPTH     = 8,
    parameter logic [3:0] IO_BASE_NIBBLE = uart_mmio_ctrl_pkg::IO_BASE_NIBBLE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wbe,
    input  logic        re,
    output logic [31:0] rdata,
    input  logic        inst_retired,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    import uart_mmio_ctrl_pkg::*;

    logic        sel, ld, st;
    logic [3:0]  off;
    logic        rx_push, rx_pop, rx_full, rx_empty;
    logic        tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0]  rx_head;
    logic [31:0] status;
    logic [31:0] rdata_d, rdata_q;
    logic [31:0] cyc_d, cyc_q;
    logic [31:0] inst_d, inst_q;
    logic        clr;
    logic        unused_ok;

    assign unused_ok = &{1'b0, addr[27:6], addr[1:0], wdata[31:8]};

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .din(rx_data),
        .full(rx_full), .empty(rx_empty), .dout(rx_head)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .din(wdata[7:0]),
        .full(tx_full), .empty(tx_empty), .dout(tx_data)
    );

    always_comb begin
        sel     = (addr[31:28] == IO_BASE_NIBBLE);
        off     = addr[5:2];
        ld      = re & sel;
        st      = (|wbe) & sel;
        rx_push = rx_valid & ~rx_full;
        rx_pop  = ld & (off == OFF_RX) & ~rx_empty;
        tx_pop  = ~tx_empty & tx_ready;
        // A drain in the same cycle frees a slot, so a store to a full FIFO still lands.
        tx_push = st & (off == OFF_TX) & (~tx_full | tx_pop);
        clr     = st & (off == OFF_CLR);

        status                    = '0;
        status[STAT_TX_NOT_FULL]  = ~tx_full;
        status[STAT_RX_NOT_EMPTY] = ~rx_empty;

        rdata_d = rdata_q;
        if (ld) begin
            case (off)
                OFF_STATUS: rdata_d = status;
                OFF_RX:     rdata_d = rx_empty ? 32'h0 : {24'h0, rx_head};
                OFF_CYC:    rdata_d = cyc_q;
                OFF_INST:   rdata_d = inst_q;
                default:    rdata_d = 32'h0;
            endcase
        end

        cyc_d  = clr ? 32'h0 : cyc_q + 32'h1;
        inst_d = clr ? 32'h0 : inst_q + {31'h0, inst_retired};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
            cyc_q   <= '0;
            inst_q  <= '0;
        end else begin
            rdata_q <= rdata_d;
            cyc_q   <= cyc_d;
            inst_q  <= inst_d;
        end
    end

    assign rdata    = rdata_q;
    assign rx_ready = ~rx_full;
    assign tx_valid = ~tx_empty;
endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Directed bench for uart_mmio_ctrl: queue-based model checked every cycle plus literal expectations.
module tb_uart_mmio_ctrl;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wbe = '0;
    logic        re = 1'b0;
    logic [31:0] rdata;
    logic        inst_retired = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    uart_mmio_ctrl #(.FIFO_DEPTH(DEPTH), .IO_BASE_NIBBLE(4'h8)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .wbe(wbe), .re(re),
        .rdata(rdata), .inst_retired(inst_retired),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    // Reference model: byte queues and plain counters.
    logic [7:0]  m_rx[$];
    logic [7:0]  m_tx[$];
    logic [31:0] m_rdata = '0;
    logic [31:0] m_cyc = '0;
    logic [31:0] m_inst = '0;

    task automatic model_reset();
        m_rx.delete();
        m_tx.delete();
        m_rdata = '0;
        m_cyc   = '0;
        m_inst  = '0;
    endtask

    task automatic model_step();
        logic        sel, store, tx_pop;
        logic [3:0]  off;
        logic [31:0] stat;
        sel   = (addr[31:28] == 4'h8);
        off   = addr[5:2];
        store = (wbe != 4'h0) && sel;
        stat  = {30'h0, m_rx.size() != 0, m_tx.size() < DEPTH};
        if (re && sel) begin
            case (off)
                4'h0: m_rdata = stat;
                4'h1: m_rdata = (m_rx.size() != 0) ? {24'h0, m_rx.pop_front()} : 32'h0;
                4'h4: m_rdata = m_cyc;
                4'h5: m_rdata = m_inst;
                default: m_rdata = 32'h0;
            endcase
        end
        if (rx_valid && m_rx.size() < DEPTH) m_rx.push_back(rx_data);
        tx_pop = tx_ready && (m_tx.size() != 0);
        if (store && off == 4'h2 && (m_tx.size() < DEPTH || tx_pop)) begin
            if (tx_pop) void'(m_tx.pop_front());
            m_tx.push_back(wdata[7:0]);
        end else if (tx_pop) begin
            void'(m_tx.pop_front());
        end
        if (store && off == 4'h6) begin
            m_cyc  = 32'h0;
            m_inst = 32'h0;
        end else begin
            m_cyc  = m_cyc + 32'h1;
            m_inst = m_inst + {31'h0, inst_retired};
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else model_step();
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("cyc_rdata", rdata, m_rdata);
            chk("cyc_rx_ready", {31'h0, rx_ready}, {31'h0, m_rx.size() < DEPTH});
            chk("cyc_tx_valid", {31'h0, tx_valid}, {31'h0, m_tx.size() != 0});
            if (m_tx.size() != 0) chk("cyc_tx_data", {24'h0, tx_data}, {24'h0, m_tx[0]});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        re   = 1'b1;
        step();
        d  = rdata;
        re = 1'b0;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wbe   = 4'hF;
        step();
        wbe = 4'h0;
    endtask

    logic [31:0] d;
    int          cnt;
    logic [7:0]  exp_b;

    initial begin
        #12;
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_rx_ready", {31'h0, rx_ready}, 32'h1);
        chk("reset_tx_valid", {31'h0, tx_valid}, 32'h0);
        chk("reset_tx_data", {24'h0, tx_data}, 32'h0);
        step();
        rst = 1'b1;

        do_load(32'h8000_0000, d); chk("status_idle", d, 32'h1);

        rx_valid = 1'b1;
        rx_data = 8'h41; step();
        rx_data = 8'h42; step();
        rx_valid = 1'b0;
        do_load(32'h8000_0000, d); chk("status_rx", d, 32'h3);
        do_load(32'h8000_0004, d); chk("rx_first", d, 32'h41);
        do_load(32'h8000_0004, d); chk("rx_second", d, 32'h42);
        do_load(32'h8000_0004, d); chk("rx_empty_load", d, 32'h0);
        do_load(32'h8000_0000, d); chk("status_back", d, 32'h1);

        rx_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            rx_data = 8'h10 + 8'(i);
            chk("rx_ready_fill", {31'h0, rx_ready}, (i < 8) ? 32'h1 : 32'h0);
            step();
        end
        rx_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            do_load(32'h8000_0004, d); chk("rx_order", d, 32'h10 + i);
        end
        do_load(32'h8000_0004, d); chk("rx_ninth_dropped", d, 32'h0);

        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            do_store(32'h8000_0008, 32'h55);
            if (i == 7) chk("tx_valid_full", {31'h0, tx_valid}, 32'h1);
        end
        do_load(32'h8000_0000, d); chk("status_tx_full", d, 32'h0);
        tx_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (tx_valid) begin
                cnt++;
                chk("tx_drain_byte", {24'h0, tx_data}, 32'h55);
            end
            step();
        end
        chk("tx_drain_count", cnt, 8);
        chk("tx_idle", {31'h0, tx_valid}, 32'h0);

        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) do_store(32'h8000_0008, 32'hA0 + i);
        tx_ready = 1'b1;
        do_store(32'h8000_0008, 32'hB0);
        tx_ready = 1'b0;
        do_load(32'h8000_0000, d); chk("tx_full_after_swap", d, 32'h0);
        tx_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (tx_valid) begin
                exp_b = (cnt < 7) ? 8'hA1 + 8'(cnt) : 8'hB0;
                chk("tx_swap_order", {24'h0, tx_data}, {24'h0, exp_b});
                cnt++;
            end
            step();
        end
        chk("tx_swap_count", cnt, 8);
        tx_ready = 1'b0;

        do_store(32'h8000_0018, 32'h0);
        for (int i = 0; i < 100; i++) begin
            inst_retired = (i % 2 == 0);
            step();
        end
        inst_retired = 1'b0;
        do_load(32'h8000_0010, d); chk("cyc_100", d, 32'd100);
        do_load(32'h8000_0014, d); chk("inst_50", d, 32'd50);
        inst_retired = 1'b1;
        do_store(32'h8000_0018, 32'h0);
        inst_retired = 1'b0;
        do_load(32'h8000_0010, d); chk("cyc_clr", d, 32'h0);
        do_load(32'h8000_0014, d); chk("inst_clr", d, 32'h0);
        do_load(32'h8000_0010, d); chk("cyc_after_clr", d, 32'h2);

        force dut.cyc_q = 32'hFFFF_FFFF;
        release dut.cyc_q;
        m_cyc = 32'hFFFF_FFFF;
        do_load(32'h8000_0010, d); chk("cyc_max", d, 32'hFFFF_FFFF);
        do_load(32'h8000_0010, d); chk("cyc_wrap", d, 32'h0);

        rx_valid = 1'b1; rx_data = 8'h77;
        do_load(32'h8000_0004, d); chk("rx_pop_empty_push", d, 32'h0);
        rx_data = 8'h78;
        do_load(32'h8000_0004, d); chk("rx_push_pop", d, 32'h77);
        rx_valid = 1'b0;
        do_load(32'h8000_0004, d); chk("rx_after_pushpop", d, 32'h78);
        do_load(32'h8000_0004, d); chk("rx_drained", d, 32'h0);

        addr = 32'h8000_0000; re = 1'b1; wbe = 4'h1; wdata = 32'h0;
        step();
        re = 1'b0; wbe = 4'h0;
        chk("status_with_store", rdata, 32'h1);
        addr = 32'h8000_0008; re = 1'b1; wdata = 32'h0000_00C3; wbe = 4'hF;
        step();
        re = 1'b0; wbe = 4'h0;
        chk("load_tx_wo", rdata, 32'h0);
        chk("store_tx_data", {24'h0, tx_data}, 32'hC3);
        do_load(32'h8000_0020, d); chk("load_unmapped", d, 32'h0);
        do_load(32'h8000_0010, d);
        do_load(32'h1000_0010, d); chk("load_unselected_holds", d, m_rdata);
        chk("load_unselected_nonzero", {31'h0, d != 32'h0}, 32'h1);

        rx_valid = 1'b1; rx_data = 8'h99; step(); rx_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("midreset_rdata", rdata, 32'h0);
        chk("midreset_rx_ready", {31'h0, rx_ready}, 32'h1);
        chk("midreset_tx_valid", {31'h0, tx_valid}, 32'h0);
        step();
        rst = 1'b1;
        do_load(32'h8000_0000, d); chk("status_after_reset", d, 32'h1);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
